coffee_dispense_ctrl: RTL

//  Multi-spout dispense sequencer; generalised successor of the single-channel dispenser.

---
 rtl/coffee_pkg.sv | 17 +
 rtl/phase_timer.sv | 26 ++
 rtl/coffee_dispense_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/coffee_pkg.sv
// Shared types and constants for the coffee dispense sequencer.
package coffee_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRIND = 3'd1,
    HEAT  = 3'd2,
    POUR  = 3'd3,
    DONE  = 3'd4
  } disp_state_t;

  typedef logic [1:0] strength_t;

  localparam logic ERR_NONE  = 1'b0;
  localparam logic ERR_ABORT = 1'b1;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter shared by all dispense phases; expired_c flags a zero count.
module phase_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/coffee_dispense_ctrl.sv
// Multi-spout dispense sequencer: grind -> heat -> pour -> completion callback.
// Optional cup sensing is enabled by defining CUP_SENSE_EN.
module coffee_dispense_ctrl
  import coffee_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned TIMER_W      = 16,
  parameter int unsigned GRIND_CYCLES = 200,
  parameter int unsigned HEAT_TIMEOUT = 1000,
  parameter int unsigned POUR_BASE    = 100,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [CH_W-1:0]   disp_ch,
  input  strength_t         disp_strength,
  input  logic              temp_ok,
`ifdef CUP_SENSE_EN
  input  logic [NUM_CH-1:0] cup_present,
`endif
  output logic              grinder_on,
  output logic              heater_on,
  output logic [NUM_CH-1:0] valve_on,
  output logic              done_valid,
  output logic [CH_W-1:0]   done_ch,
  output logic              done_err,
  input  logic              done_ack
);

  disp_state_t        state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d, done_ch_d;
  strength_t          str_q, str_d;
  logic               err_d;
  logic               tmr_load, tmr_expired_c;
  logic [TIMER_W-1:0] tmr_val, pour_len_c;
  logic               bad_ch_c, cup_ok_c, cup_now_c;
  logic [NUM_CH-1:0]  valve_d;

  phase_timer #(.W(TIMER_W)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .expired_c (tmr_expired_c)
  );

  assign bad_ch_c   = (int'(disp_ch) >= NUM_CH);
  assign pour_len_c = TIMER_W'(POUR_BASE) * (TIMER_W'(str_q) + TIMER_W'(1));

  // A bad channel never reaches the cup lookup; it goes straight to an error callback.
`ifdef CUP_SENSE_EN
  assign cup_ok_c  = bad_ch_c ? 1'b1 : cup_present[disp_ch];
  assign cup_now_c = cup_present[ch_q];
`else
  assign cup_ok_c  = 1'b1;
  assign cup_now_c = 1'b1;
`endif

  // Next-state, latch and timer-load decisions.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    str_d     = str_q;
    err_d     = done_err;
    done_ch_d = done_ch;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    unique case (state_q)
      IDLE: begin
        if (disp_valid && cup_ok_c) begin
          ch_d  = disp_ch;
          str_d = disp_strength;
          if (bad_ch_c) begin
            state_d   = DONE;
            err_d     = ERR_ABORT;
            done_ch_d = disp_ch;
          end else begin
            state_d  = GRIND;
            tmr_load = 1'b1;
            tmr_val  = TIMER_W'(GRIND_CYCLES - 1);
          end
        end
      end
      GRIND: begin
        if (tmr_expired_c) begin
          state_d  = HEAT;
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(HEAT_TIMEOUT - 1);
        end
      end
      HEAT: begin
        // temp_ok wins over a simultaneous timeout.
        if (temp_ok) begin
          state_d  = POUR;
          tmr_load = 1'b1;
          tmr_val  = pour_len_c - TIMER_W'(1);
        end else if (tmr_expired_c) begin
          state_d   = DONE;
          err_d     = ERR_ABORT;
          done_ch_d = ch_q;
        end
      end
      POUR: begin
        if (!cup_now_c) begin
          state_d   = DONE;
          err_d     = ERR_ABORT;
          done_ch_d = ch_q;
        end else if (tmr_expired_c) begin
          state_d   = DONE;
          err_d     = ERR_NONE;
          done_ch_d = ch_q;
        end
      end
      DONE: begin
        if (done_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign valve_d = (state_d == POUR) ? (NUM_CH'(1) << ch_d) : '0;

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      str_q      <= '0;
      disp_ready <= 1'b1;
      grinder_on <= 1'b0;
      heater_on  <= 1'b0;
      valve_on   <= '0;
      done_valid <= 1'b0;
      done_ch    <= '0;
      done_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      str_q      <= str_d;
      disp_ready <= (state_d == IDLE);
      grinder_on <= (state_d == GRIND);
      heater_on  <= (state_d == HEAT) || (state_d == POUR);
      valve_on   <= valve_d;
      done_valid <= (state_d == DONE);
      done_ch    <= done_ch_d;
      done_err   <= err_d;
    end
  end

endmodule
